mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait latency.
// Requests are latched on acceptance; the array is touched on entry to RESP.
module mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [2:0]  LAT     = 3'(LATENCY);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              a_write;
    logic [31:0]       a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [31:0]       widx;
    logic              a_err;
    logic [AW-1:0]     mem_idx;
    logic              mem_we;

    // With zero latency the accept edge is also the RESP-entry edge,
    // so the access must see the fields being latched on that edge.
    always_comb begin
        accept     = (state_q == IDLE) && req_valid;
        enter_resp = (accept && (LAT == 3'd0)) ||
                     ((state_q == WAIT) && (cnt_q == 3'd1));
        a_write    = accept ? req_write : write_q;
        a_addr     = accept ? req_addr  : addr_q;
        a_wdata    = accept ? req_wdata : wdata_q;
        widx       = {2'b00, a_addr[31:2]};
        a_err      = (a_addr[1:0] != 2'b00) || (widx >= DEPTH_W);
        mem_idx    = widx[AW-1:0];
        mem_we     = rst && enter_resp && a_write && !a_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = LAT;
                    state_d = (LAT == 3'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_resp) begin
            err_d   = a_err;
            rdata_d = (a_err || a_write) ? '0 : mem[mem_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= a_wdata;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 and LATENCY=0 instances share stimulus,
// each checked every cycle against a transaction-level model.
module tb_mem_responder;

    localparam int DEP = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic        rsp_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rdy [2];
    logic        vld [2];
    logic        er  [2];
    logic [31:0] rd  [2];

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .DEPTH(DEP), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy[0]), .rsp_valid(vld[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0])
    );

    mem_responder #(.DATA_W(32), .DEPTH(DEP), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy[1]), .rsp_valid(vld[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1])
    );

    int checks = 0;
    int errors = 0;

    int          lat_of [2] = '{2, 0};
    int          cyc = 0;
    bit          mbusy [2];
    bit          minresp [2];
    bit          mw [2];
    bit          merr [2];
    bit          mknown [2];
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic [31:0] mrd [2];
    int          macc [2];
    bit   [31:0] mm [2][DEP];
    bit          mk [2][DEP];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEP);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mbusy[k]   = 1'b0;
            minresp[k] = 1'b0;
        end
    endtask

    // Transaction view: a request answers lat cycles after acceptance.
    task automatic model_step();
        int idx;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mbusy[k]   = 1'b0;
                minresp[k] = 1'b0;
            end else begin
                if (!mbusy[k]) begin
                    if (req_valid) begin
                        mbusy[k]   = 1'b1;
                        minresp[k] = 1'b0;
                        macc[k]    = cyc;
                        mw[k]      = req_write;
                        ma[k]      = req_addr;
                        md[k]      = req_wdata;
                    end
                end else if (minresp[k] && rsp_ready) begin
                    mbusy[k]   = 1'b0;
                    minresp[k] = 1'b0;
                end
                if (mbusy[k] && !minresp[k] && (cyc - macc[k] >= lat_of[k])) begin
                    minresp[k] = 1'b1;
                    merr[k]    = addr_bad(ma[k]);
                    mknown[k]  = 1'b1;
                    mrd[k]     = 32'h0;
                    if (!merr[k]) begin
                        idx = int'(ma[k] / 4);
                        if (mw[k]) begin
                            mm[k][idx] = md[k];
                            mk[k][idx] = 1'b1;
                        end else begin
                            mrd[k]    = mm[k][idx];
                            mknown[k] = mk[k][idx];
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare();
        bit ev;
        for (int k = 0; k < 2; k++) begin
            ev = mbusy[k] && minresp[k];
            chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!mbusy[k]));
            chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(ev));
            chk($sformatf("err%0d", k), 32'(er[k]), 32'(ev && merr[k]));
            if (!ev || mknown[k]) begin
                chk($sformatf("rdata%0d", k), rd[k], ev ? mrd[k] : 32'h0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_req(input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          input int hold,
                          output logic [31:0] rda, output bit era,
                          output int la, output int lb,
                          output logic [31:0] rdb);
        for (int i = 0; i < 20 && !(rdy[0] && rdy[1]); i++) cycle();
        chk("idle_wait", 32'(rdy[0] && rdy[1]), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = (hold == 0);
        cycle();
        req_valid = 1'b0;
        if (scramble) begin
            req_addr  = a + 32'd4;
            req_wdata = ~d;
        end
        la  = 1;
        lb  = 0;
        rdb = 32'h0;
        if (vld[1]) begin
            lb  = 1;
            rdb = rd[1];
        end
        while (!vld[0] && la < 20) begin
            cycle();
            la++;
            if (vld[1] && lb == 0) begin
                lb  = la;
                rdb = rd[1];
            end
        end
        chk("rsp_timeout", 32'(vld[0]), 32'd1);
        rda = rd[0];
        era = er[0];
        for (int i = 0; i < hold; i++) begin
            cycle();
            chk("hold_valid", 32'(vld[0]), 32'd1);
            chk("hold_rdata", rd[0], rda);
            chk("hold_ready", 32'(rdy[0]), 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        if (hold > 0) begin
            chk("release_ready", 32'(rdy[0]), 32'd1);
            chk("release_valid", 32'(vld[0]), 32'd0);
        end
    endtask

    task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 20 && !(rdy[0] && rdy[1]); i++) cycle();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_ready", 32'(rdy[0]), 32'd1);
        chk("arst_valid", 32'(vld[0]), 32'd0);
        chk("arst_rdata", rd[0], 32'h0);
        chk("arst_err", 32'(er[0]), 32'd0);
        chk("arst_valid_l0", 32'(vld[1]), 32'd0);
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 15));
        case ($urandom_range(0, 15))
            10, 11:  return (w << 2) | 32'($urandom_range(1, 3));
            12:      return 32'h400;
            13:      return 32'h3FC;
            14:      return $urandom;
            15:      return 32'hFFFF_FFFC;
            default: return w << 2;
        endcase
    endfunction

    initial begin
        logic [31:0] rda, rdb;
        bit          era;
        int          la, lb;

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
            chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
            chk($sformatf("rst_err%0d", k), 32'(er[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rd[k], 32'h0);
        end
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 0, rda, era, la, lb, rdb);
        chk("st10_lat", 32'(la), 32'd3);
        chk("st10_lat_l0", 32'(lb), 32'd1);
        chk("st10_err", 32'(era), 32'd0);
        chk("st10_rdata", rda, 32'h0);

        do_req(1'b0, 32'h10, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        chk("ld10_rdata", rda, 32'hDEAD_BEEF);
        chk("ld10_err", 32'(era), 32'd0);
        chk("ld10_lat_l0", 32'(lb), 32'd1);
        chk("ld10_rdata_l0", rdb, 32'hDEAD_BEEF);

        do_req(1'b0, 32'h13, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        chk("ld13_err", 32'(era), 32'd1);
        chk("ld13_rdata", rda, 32'h0);
        do_req(1'b0, 32'h400, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        chk("ld400_err", 32'(era), 32'd1);
        chk("ld400_rdata", rda, 32'h0);
        do_req(1'b1, 32'h412, 32'h5555_5555, 1'b0, 0, rda, era, la, lb, rdb);
        chk("st412_err", 32'(era), 32'd1);
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        chk("ld10_again", rda, 32'hDEAD_BEEF);

        do_req(1'b0, 32'h10, 32'h0, 1'b0, 5, rda, era, la, lb, rdb);
        chk("hold_data", rda, 32'hDEAD_BEEF);

        do_req(1'b1, 32'h34, 32'h1111_1111, 1'b0, 0, rda, era, la, lb, rdb);
        do_req(1'b1, 32'h30, 32'hA5A5_A5A5, 1'b1, 0, rda, era, la, lb, rdb);
        do_req(1'b0, 32'h30, 32'h0, 1'b1, 0, rda, era, la, lb, rdb);
        chk("scr_ld30", rda, 32'hA5A5_A5A5);
        do_req(1'b0, 32'h34, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        chk("scr_ld34", rda, 32'h1111_1111);

        do_req(1'b1, 32'h24, 32'hCAFE_0001, 1'b0, 0, rda, era, la, lb, rdb);
        reset_mid_wait(32'h24, 32'h0BAD_F00D);
        do_req(1'b0, 32'h24, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        chk("abandon_ld24", rda, 32'hCAFE_0001);
        reset_mid_wait(32'h20, 32'h1234_5678);
        do_req(1'b1, 32'h20, 32'h0, 1'b0, 0, rda, era, la, lb, rdb);
        do_req(1'b0, 32'h20, 32'hFFFF_FFFF, 1'b0, 0, rda, era, la, lb, rdb);
        chk("abandon_ld20", rda, 32'h0);
        chk("abandon_ld20_lat", 32'(la), 32'd3);

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!rst) model_reset();
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = pick_addr();
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 15; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
